int_entry_seq: RTL

Interrupt entry sequencer for the bc6502 core. It consumes the interrupt-type flags (firq, fnmi, fbrk) at an instruction boundary and performs the entry sequence: push PCH, PCL and SR to the stack, then fetch the vector. When done it loads PC and SP, sets the I flag, and pulses int4, which clears the type flags upstream and acknowledges the NMI latch.

---
 rtl/int_entry_seq.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/int_entry_seq.sv
// ---------------------------------------------------------------------------
// int_entry_seq
//
// Interrupt entry sequencer for the bc6502 core. At an instruction boundary
// it takes the pending interrupt type (IRQ, NMI, BRK) and runs the entry
// sequence:
//   1. Push PCH, PCL and SR to the stack page (0x01xx).
//   2. Read the vector low and high bytes.
//   3. Load PC and SP, set the I flag, and pulse int4 for one
//      pipe_ce-qualified cycle.
//
// Ports
//   clk, rst         clock; synchronous active-high reset
//   pipe_ce          pipeline clock enable; nothing advances while low
//   start            instruction-boundary request
//   firq/fnmi/fbrk   pending interrupt type flags
//   pc_i/sp_i/sr_i   return PC, stack pointer and status to save
//   ack_i, dat_i     bus acknowledge and read data
//   cyc_o, we_o      bus cycle and write enable
//   ad_o, dat_o      bus address and write data
//   pc_o, pc_we      fetched vector and PC load strobe
//   sp_o, sp_we      new stack pointer and SP load strobe
//   set_i, clr_d     I-flag set and D-flag clear strobes
//   int4             entry complete; clears the type flags upstream
//   nmi_ack          clears the upstream NMI edge latch
//   busy             high whenever a sequence is in progress
// ---------------------------------------------------------------------------
module int_entry_seq #(
    parameter logic [15:0] NMI_VEC = 16'hFFFA,
    parameter logic [15:0] IRQ_VEC = 16'hFFFE,
    parameter bit          CMOS    = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_ce,
    input  logic        start,
    input  logic        firq,
    input  logic        fnmi,
    input  logic        fbrk,
    input  logic [15:0] pc_i,
    input  logic [7:0]  sp_i,
    input  logic [7:0]  sr_i,
    input  logic        ack_i,
    input  logic [7:0]  dat_i,
    output logic        cyc_o,
    output logic        we_o,
    output logic [15:0] ad_o,
    output logic [7:0]  dat_o,
    output logic [15:0] pc_o,
    output logic        pc_we,
    output logic [7:0]  sp_o,
    output logic        sp_we,
    output logic        set_i,
    output logic        clr_d,
    output logic        int4,
    output logic        nmi_ack,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE,
        PUSH_PCH,
        PUSH_PCL,
        PUSH_SR,
        VEC_LO,
        VEC_HI,
        DONE
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [15:0] pc_q;
    logic [7:0]  sp_q;
    logic [7:0]  sr_q;
    logic        is_nmi;
    logic        bflag;
    logic [15:0] vec_q;

    logic        accept;
    logic        step;
    logic [15:0] vec;

    assign accept = pipe_ce & start & (firq | fnmi | fbrk);
    assign step   = pipe_ce & ack_i;

    // NMI takes the vector even when the entry was caused by BRK; the pushed
    // B bit still records the BRK.
    assign vec    = is_nmi ? NMI_VEC : IRQ_VEC;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. Bus states wait for an acknowledged, enabled cycle;
    // DONE holds its strobes until the pipeline actually consumes them.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (accept)  state_nxt = PUSH_PCH;
            PUSH_PCH: if (step)    state_nxt = PUSH_PCL;
            PUSH_PCL: if (step)    state_nxt = PUSH_SR;
            PUSH_SR:  if (step)    state_nxt = VEC_LO;
            VEC_LO:   if (step)    state_nxt = VEC_HI;
            VEC_HI:   if (step)    state_nxt = DONE;
            DONE:     if (pipe_ce) state_nxt = IDLE;
            default:               state_nxt = IDLE;
        endcase
    end

    // Working registers: capture the context on acceptance, walk the stack
    // pointer down on each acknowledged push, and assemble the vector.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q   <= 16'h0000;
            sp_q   <= 8'h00;
            sr_q   <= 8'h00;
            is_nmi <= 1'b0;
            bflag  <= 1'b0;
            vec_q  <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        pc_q   <= pc_i;
                        sp_q   <= sp_i;
                        sr_q   <= sr_i;
                        is_nmi <= fnmi;
                        bflag  <= fbrk;
                    end
                end
                PUSH_PCH, PUSH_PCL, PUSH_SR: begin
                    if (step) sp_q <= sp_q - 8'd1;
                end
                VEC_LO: begin
                    if (step) vec_q[7:0] <= dat_i;
                end
                VEC_HI: begin
                    if (step) vec_q[15:8] <= dat_i;
                end
                default: ;
            endcase
        end
    end

    assign pc_o = vec_q;
    assign busy = (state != IDLE);

    // Bus and strobe outputs decoded from the state. Everything is zero
    // outside the states that drive it.
    always_comb begin
        cyc_o   = 1'b0;
        we_o    = 1'b0;
        ad_o    = 16'h0000;
        dat_o   = 8'h00;
        pc_we   = 1'b0;
        sp_o    = 8'h00;
        sp_we   = 1'b0;
        set_i   = 1'b0;
        clr_d   = 1'b0;
        int4    = 1'b0;
        nmi_ack = 1'b0;
        case (state)
            PUSH_PCH: begin
                cyc_o = 1'b1;
                we_o  = 1'b1;
                ad_o  = {8'h01, sp_q};
                dat_o = pc_q[15:8];
            end
            PUSH_PCL: begin
                cyc_o = 1'b1;
                we_o  = 1'b1;
                ad_o  = {8'h01, sp_q};
                dat_o = pc_q[7:0];
            end
            PUSH_SR: begin
                // Bit 5 always reads as 1 on the stack; bit 4 is the B flag.
                cyc_o = 1'b1;
                we_o  = 1'b1;
                ad_o  = {8'h01, sp_q};
                dat_o = {sr_q[7:6], 1'b1, bflag, sr_q[3:0]};
            end
            VEC_LO: begin
                cyc_o = 1'b1;
                ad_o  = vec;
            end
            VEC_HI: begin
                cyc_o = 1'b1;
                ad_o  = vec + 16'd1;
            end
            DONE: begin
                // Three pushes have already taken sp_q down by three.
                pc_we   = 1'b1;
                sp_we   = 1'b1;
                sp_o    = sp_q;
                set_i   = 1'b1;
                clr_d   = CMOS;
                int4    = 1'b1;
                nmi_ack = is_nmi;
            end
            default: ;
        endcase
    end

endmodule
